// File: rtl/ara_uart_cfg_ctrl.sv
// Boot-time UART configuration sequencer. It programs the divisor, LCR and FCR
// over APB, then forwards the SoC APB master to the UART transparently.
module ara_uart_cfg_ctrl #(
  parameter int unsigned ClkFreqHz = 50_000_000,
  parameter int unsigned BaudRate  = 115200,
  parameter logic [7:0]  LcrValue  = 8'h03,
  parameter logic [7:0]  FcrValue  = 8'hC7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reinit_i,
  output logic        init_done_o,
  output logic        init_err_o,
  input  logic        s_psel_i,
  input  logic        s_penable_i,
  input  logic        s_pwrite_i,
  input  logic [31:0] s_paddr_i,
  input  logic [31:0] s_pwdata_i,
  output logic [31:0] s_prdata_o,
  output logic        s_pready_o,
  output logic        s_pslverr_o,
  output logic        m_psel_o,
  output logic        m_penable_o,
  output logic        m_pwrite_o,
  output logic [31:0] m_paddr_o,
  output logic [31:0] m_pwdata_o,
  input  logic [31:0] m_prdata_i,
  input  logic        m_pready_i,
  input  logic        m_pslverr_i
);

  localparam int unsigned StepW = 3;
  localparam logic [StepW-1:0] LastStep = 3'd4;

  // Rounded divisor: (f + 8*baud) / (16*baud)
  localparam longint unsigned DivFull =
    (64'(ClkFreqHz) + 64'd8 * 64'(BaudRate)) / (64'd16 * 64'(BaudRate));
  localparam logic [15:0] Div = 16'(DivFull);

  generate
    if (DivFull < 64'd1 || DivFull > 64'd65535) begin : g_div_range
      $error("ara_uart_cfg_ctrl: baud divisor out of range 1..65535");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_SETUP  = 2'd0,
    ST_ACCESS = 2'd1,
    ST_PASS   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [StepW-1:0] step_q, step_d;
  logic             err_q, err_d;
  logic             pending_q, pending_d;
  logic             reinit_req;

  logic [2:0] step_idx;
  logic [7:0] step_data;
  logic       pass;

  // Init write table: register index and byte per step
  always_comb begin
    step_idx  = 3'd0;
    step_data = 8'h00;
    case (step_q)
      3'd0: begin step_idx = 3'd3; step_data = 8'h80;      end
      3'd1: begin step_idx = 3'd0; step_data = Div[7:0];   end
      3'd2: begin step_idx = 3'd1; step_data = Div[15:8];  end
      3'd3: begin step_idx = 3'd3; step_data = LcrValue;   end
      3'd4: begin step_idx = 3'd2; step_data = FcrValue;   end
      default: begin step_idx = 3'd0; step_data = 8'h00;   end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_SETUP;
      step_q    <= '0;
      err_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      err_q     <= err_d;
      pending_q <= pending_d;
    end
  end

  // A re-init request waits until the upstream bus is idle
  assign reinit_req = pending_q | reinit_i;

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    err_d     = err_q;
    pending_d = 1'b0;
    case (state_q)
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (m_pready_i) begin
          if (m_pslverr_i) err_d = 1'b1;
          if (step_q == LastStep) begin
            state_d = ST_PASS;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = ST_SETUP;
          end
        end
      end
      ST_PASS: begin
        pending_d = reinit_req;
        if (reinit_req && !s_psel_i) begin
          state_d   = ST_SETUP;
          step_d    = '0;
          err_d     = 1'b0;
          pending_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_SETUP;
        step_d  = '0;
      end
    endcase
  end

  assign pass = (state_q == ST_PASS);

  // Pass-through mux; outside PASS the FSM owns the UART port
  assign m_psel_o    = pass ? s_psel_i    : 1'b1;
  assign m_penable_o = pass ? s_penable_i : (state_q == ST_ACCESS);
  assign m_pwrite_o  = pass ? s_pwrite_i  : 1'b1;
  assign m_paddr_o   = pass ? s_paddr_i   : {27'b0, step_idx, 2'b00};
  assign m_pwdata_o  = pass ? s_pwdata_i  : {24'b0, step_data};

  assign s_prdata_o  = pass ? m_prdata_i  : 32'h0;
  assign s_pready_o  = pass ? m_pready_i  : 1'b0;
  assign s_pslverr_o = pass ? m_pslverr_i : 1'b0;

  assign init_done_o = pass;
  assign init_err_o  = err_q;

endmodule
